l1_mau_responder: RTL

//  Memory-side responder for the L1 MAU request interface: accepts one L1 request at a time, services it

---
 rtl/l1_mau_responder_if.sv | 54 +++++
 rtl/l1_mau_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/l1_mau_responder_if.sv
// l1_mau_responder_if
//   Groups the two buses of the L1 MAU responder.
//   - L1 side: a request is held until a one-cycle ack returns.
//   - Memory side: a word-wide request/ready handshake, plus an in-order read response.
//   Modports:
//     slave  : the responder's view of the buses (drives the ack and the memory request).
//     master : the environment's view (drives the L1 request, memory ready and response).
//   Signals:
//     mau_req_val/nc/we/addr/wdata/be  L1 request (wdata/be byte-0 justified)
//     mau_req_ack, mau_ack_nc/we/data  completion pulse and echoed attributes / line data
//     mem_req_val/we/addr/wdata/be     word-aligned memory request, lane-shifted data/enables
//     mem_req_rdy                      memory accepts when val & rdy
//     mem_rsp_val/data                 one read return per accepted read, in order
interface l1_mau_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
);
  localparam int BE_W = DATA_W / 8;

  logic              mau_req_val;
  logic              mau_req_nc;
  logic              mau_req_we;
  logic [ADDR_W-1:0] mau_req_addr;
  logic [DATA_W-1:0] mau_req_wdata;
  logic [BE_W-1:0]   mau_req_be;
  logic              mau_req_ack;
  logic              mau_ack_nc;
  logic              mau_ack_we;
  logic [LINE_W-1:0] mau_ack_data;

  logic              mem_req_val;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [BE_W-1:0]   mem_req_be;
  logic              mem_req_rdy;
  logic              mem_rsp_val;
  logic [DATA_W-1:0] mem_rsp_data;

  modport slave (
    input  mau_req_val, mau_req_nc, mau_req_we, mau_req_addr, mau_req_wdata, mau_req_be,
    output mau_req_ack, mau_ack_nc, mau_ack_we, mau_ack_data,
    output mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_rdy, mem_rsp_val, mem_rsp_data
  );

  modport master (
    output mau_req_val, mau_req_nc, mau_req_we, mau_req_addr, mau_req_wdata, mau_req_be,
    input  mau_req_ack, mau_ack_nc, mau_ack_we, mau_ack_data,
    input  mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_rdy, mem_rsp_val, mem_rsp_data
  );
endinterface

// File: rtl/l1_mau_responder.sv
// l1_mau_responder
//   Memory-side responder for the L1 MAU request interface.
//   - Accepts one L1 request at a time and services it against a word-wide backing memory.
//   - Returns a single-cycle ack when the request completes.
//   Request types:
//   - Cacheable read: a line fill of LINE_W/DATA_W sequential word reads, one outstanding at a time.
//   - Non-cacheable read: one word, returned in the top word of the ack data.
//   - Write (cacheable or not): one word, with data and enables lane-shifted by the byte offset.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset; aborts any transaction in flight without an ack
//     bus    l1_mau_responder_if.slave (L1 request/ack bus and backing-memory bus)
module l1_mau_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  l1_mau_responder_if.slave  bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WORDS  = LINE_W / DATA_W;
  localparam int CNT_W  = $clog2(WORDS);
  localparam int OFF_W  = $clog2(BE_W);
  localparam int LOFF_W = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    NC_RD,
    NC_WAIT,
    FILL_REQ,
    FILL_WAIT,
    ACK
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;
  logic              nc_q;
  logic              we_q;
  logic              ack_q;
  logic              mem_val_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;

  // Enables move up by the byte offset; any enable pushed past the top lane is dropped.
  function automatic logic [BE_W-1:0] lane_be(input logic [BE_W-1:0] be,
                                              input logic [OFF_W-1:0] off);
    return be << off;
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [DATA_W-1:0] d,
                                                   input logic [OFF_W-1:0] off);
    return d << {off, 3'b000};
  endfunction

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] fill_base;

  assign word_addr = {bus.mau_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  // Line fills always start at the line boundary, even if L1 sends an unaligned address.
  assign fill_base = {bus.mau_req_addr[ADDR_W-1:LOFF_W], {LOFF_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      nc_q        <= 1'b0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      mem_val_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mau_req_val) begin
            nc_q      <= bus.mau_req_nc;
            we_q      <= bus.mau_req_we;
            line_q    <= '0;
            cnt_q     <= '0;
            mem_val_q <= 1'b1;
            if (bus.mau_req_we) begin
              state_q     <= WR;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_addr;
              mem_wdata_q <= lane_wdata(bus.mau_req_wdata, bus.mau_req_addr[OFF_W-1:0]);
              mem_be_q    <= lane_be(bus.mau_req_be, bus.mau_req_addr[OFF_W-1:0]);
            end else if (bus.mau_req_nc) begin
              state_q     <= NC_RD;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= word_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end else begin
              state_q     <= FILL_REQ;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= fill_base;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end
          end
        end
        WR: begin
          if (bus.mem_req_rdy) begin
            mem_val_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ACK;
            ack_q     <= 1'b1;
          end
        end
        NC_RD: begin
          if (bus.mem_req_rdy) begin
            mem_val_q <= 1'b0;
            state_q   <= NC_WAIT;
          end
        end
        NC_WAIT: begin
          if (bus.mem_rsp_val) begin
            line_q  <= {bus.mem_rsp_data, {(LINE_W-DATA_W){1'b0}}};
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        FILL_REQ: begin
          if (bus.mem_req_rdy) begin
            mem_val_q <= 1'b0;
            state_q   <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_rsp_val) begin
            for (int w = 0; w < WORDS; w++) begin
              if (cnt_q == CNT_W'(w)) line_q[w*DATA_W +: DATA_W] <= bus.mem_rsp_data;
            end
            if (cnt_q == CNT_W'(WORDS-1)) begin
              cnt_q   <= '0;
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              // Next word request goes out on the same edge the response lands.
              cnt_q      <= cnt_q + CNT_W'(1);
              mem_val_q  <= 1'b1;
              mem_addr_q <= mem_addr_q + ADDR_W'(BE_W);
              state_q    <= FILL_REQ;
            end
          end
        end
        ACK: begin
          // L1 still holds val during this cycle; returning to IDLE here keeps it from
          // being taken as a second request.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mau_req_ack   = ack_q;
  assign bus.mau_ack_nc    = ack_q & nc_q;
  assign bus.mau_ack_we    = ack_q & we_q;
  assign bus.mau_ack_data  = ack_q ? line_q : '0;
  assign bus.mem_req_val   = mem_val_q;
  assign bus.mem_req_we    = mem_we_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.mem_req_wdata = mem_wdata_q;
  assign bus.mem_req_be    = mem_be_q;

  a_words_pow2: assert property (@(posedge clk)
    (WORDS >= 2) && ((WORDS & (WORDS - 1)) == 0));

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.mau_req_val && !bus.mau_req_ack) |=>
      (bus.mau_req_val && $stable(bus.mau_req_nc) && $stable(bus.mau_req_we) &&
       $stable(bus.mau_req_addr) && $stable(bus.mau_req_wdata) && $stable(bus.mau_req_be)));

  a_rsp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_rsp_val |-> (state_q == NC_WAIT || state_q == FILL_WAIT));

endmodule
